// File: rtl/irrigation_sequencer_if.sv
// Sensor, command and actuator signals of the irrigation sequencer.
// The controller side uses the slave modport; the environment uses master.
interface irrigation_sequencer_if;
  logic       tick;
  logic       low_water_level;
  logic       mid_water_level;
  logic       high_water_level;
  logic       earth_humidity;
  logic       air_humidity;
  logic       low_temperature;
  logic       start_request;
  logic       abort;
  logic       splinker_bomb;
  logic       dripper_valvule;
  logic       water_supply_valvule;
  logic       alarm;
  logic       busy;
  logic [2:0] state;
  logic [9:0] remaining;

  modport master (
    output tick, low_water_level, mid_water_level, high_water_level,
           earth_humidity, air_humidity, low_temperature, start_request, abort,
    input  splinker_bomb, dripper_valvule, water_supply_valvule, alarm, busy,
           state, remaining
  );

  modport slave (
    input  tick, low_water_level, mid_water_level, high_water_level,
           earth_humidity, air_humidity, low_temperature, start_request, abort,
    output splinker_bomb, dripper_valvule, water_supply_valvule, alarm, busy,
           state, remaining
  );
endinterface

// File: rtl/irrigation_sequencer.sv
// Tank-fed irrigation controller: settle, irrigate (sprinkler or dripper),
// refill and hold-off phases timed in ticks, with level-sensor fault detection.
module irrigation_sequencer #(
  parameter int SETTLE_TIME     = 3,
  parameter int IRRIGATION_TIME = 300,
  parameter int HOLDOFF_TIME    = 10,
  parameter int REFILL_TIMEOUT  = 120
) (
  input logic             clock,
  input logic             reset_n,
  irrigation_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    IRRIGATE = 3'd2,
    REFILL   = 3'd3,
    HOLDOFF  = 3'd4,
    FAULT    = 3'd5
  } state_t;

  localparam logic [9:0] SETTLE_LOAD   = 10'(SETTLE_TIME);
  localparam logic [9:0] IRRIGATE_LOAD = 10'(IRRIGATION_TIME);
  localparam logic [9:0] HOLDOFF_LOAD  = 10'(HOLDOFF_TIME);
  localparam logic [9:0] REFILL_LOAD   = 10'(REFILL_TIMEOUT);

  state_t     state_reg, state_next;
  logic [9:0] remaining_reg, remaining_next;
  logic       sprinkler_reg, sprinkler_next;
  logic       splinker_reg, dripper_reg, supply_reg, alarm_reg, busy_reg;
  logic       conflict, expired;

  // Any upper sensor wet while a lower one is dry means a broken sensor.
  assign conflict = (bus.high_water_level & ~bus.mid_water_level) |
                    (bus.mid_water_level  & ~bus.low_water_level) |
                    (bus.high_water_level & ~bus.low_water_level);
  assign expired  = bus.tick & (remaining_reg == 10'd1);

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    sprinkler_next = sprinkler_reg;
    if (bus.tick && remaining_reg != 10'd0)
      remaining_next = remaining_reg - 10'd1;

    case (state_reg)
      IDLE: begin
        if (conflict)                                   state_next = FAULT;
        else if (!bus.low_water_level)                  state_next = REFILL;
        else if (!bus.earth_humidity || bus.start_request) state_next = SETTLE;
      end
      SETTLE: begin
        if (conflict)                    state_next = FAULT;
        else if (bus.abort)              state_next = IDLE;
        else if (expired)                state_next = bus.low_water_level ? IRRIGATE : REFILL;
      end
      IRRIGATE: begin
        if (conflict)                    state_next = FAULT;
        else if (bus.abort)              state_next = HOLDOFF;
        else if (!bus.low_water_level)   state_next = REFILL;
        else if (bus.earth_humidity || expired) state_next = HOLDOFF;
      end
      REFILL: begin
        if (conflict)                    state_next = FAULT;
        else if (bus.abort)              state_next = IDLE;
        else if (bus.high_water_level)   state_next = IDLE;
        else if (expired)                state_next = FAULT;
      end
      HOLDOFF: begin
        if (conflict)                    state_next = FAULT;
        else if (expired)                state_next = IDLE;
      end
      FAULT: begin
        if (bus.abort && !conflict)      state_next = IDLE;
      end
      default:                           state_next = FAULT;
    endcase

    // Entering a state loads its timer, overriding any decrement this edge.
    if (state_next != state_reg) begin
      case (state_next)
        SETTLE:   remaining_next = SETTLE_LOAD;
        IRRIGATE: begin
          remaining_next = IRRIGATE_LOAD;
          sprinkler_next = bus.mid_water_level & ~bus.air_humidity & ~bus.low_temperature;
        end
        REFILL:   remaining_next = REFILL_LOAD;
        HOLDOFF:  remaining_next = HOLDOFF_LOAD;
        default:  remaining_next = 10'd0;
      endcase
    end
    if (state_next == IDLE || state_next == FAULT)
      remaining_next = 10'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      remaining_reg <= 10'd0;
      sprinkler_reg <= 1'b0;
      splinker_reg  <= 1'b0;
      dripper_reg   <= 1'b0;
      supply_reg    <= 1'b0;
      alarm_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      sprinkler_reg <= sprinkler_next;
      splinker_reg  <= (state_next == IRRIGATE) &  sprinkler_next;
      dripper_reg   <= (state_next == IRRIGATE) & ~sprinkler_next;
      supply_reg    <= (state_next == REFILL);
      alarm_reg     <= (state_next == FAULT) | ~bus.mid_water_level;
      busy_reg      <= (state_next == SETTLE) | (state_next == IRRIGATE) |
                       (state_next == REFILL);
    end
  end

  assign bus.state                = state_reg;
  assign bus.remaining            = remaining_reg;
  assign bus.splinker_bomb        = splinker_reg;
  assign bus.dripper_valvule      = dripper_reg;
  assign bus.water_supply_valvule = supply_reg;
  assign bus.alarm                = alarm_reg;
  assign bus.busy                 = busy_reg;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer; expectations are queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_irrigation_sequencer;

  logic clock;
  logic reset_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  irrigation_sequencer_if bus ();

  irrigation_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int         tgt;
    string      name;
    logic [2:0] st;
    logic [9:0] rem;
    logic [4:0] outs;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic [4:0] mon_outs;

  localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_IRR = 3'd2,
                         S_REFILL = 3'd3, S_HOLD = 3'd4, S_FAULT = 3'd5;
  // outs = {splinker, dripper, supply, alarm, busy}
  localparam logic [4:0] O_NONE = 5'b00000, O_BUSY = 5'b00001, O_SPR = 5'b10001,
                         O_DRIP = 5'b01001, O_REF_LO = 5'b00111, O_FAULT = 5'b00010;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      mon_e    = q.pop_front();
      mon_outs = {bus.splinker_bomb, bus.dripper_valvule, bus.water_supply_valvule,
                  bus.alarm, bus.busy};
      total++;
      if (mon_e.tgt != cyc || bus.state != mon_e.st || bus.remaining != mon_e.rem ||
          mon_outs != mon_e.outs) begin
        bad++;
        $display("FAIL %s: got state=%0d rem=%0d outs=%b, want state=%0d rem=%0d outs=%b (cyc %0d/%0d)",
                 mon_e.name, bus.state, bus.remaining, mon_outs,
                 mon_e.st, mon_e.rem, mon_e.outs, cyc, mon_e.tgt);
      end else begin
        $display("check %s: state=%0d rem=%0d outs=%b ok", mon_e.name, bus.state,
                 bus.remaining, mon_outs);
      end
    end
  end

  task automatic ex(input string nm, input logic [2:0] st, input int rem,
                    input logic [4:0] o);
    exp_t e;
    e.tgt  = cyc;
    e.name = nm;
    e.st   = st;
    e.rem  = 10'(rem);
    e.outs = o;
    q.push_back(e);
  endtask

  task automatic clk1();
    @(posedge clock);
    #2;
  endtask

  task automatic tk();
    bus.tick = 1'b1;
    clk1();
    bus.tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tk();
      clk1();
    end
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    clk1();
    bus.abort = 1'b0;
  endtask

  task automatic start_irrigation(input string nm, input logic [4:0] o);
    bus.earth_humidity = 1'b0;
    clk1();
    ex({nm, "_settle"}, S_SETTLE, 3, O_BUSY);
    tk();
    tk();
    tk();
    ex({nm, "_irr_entry"}, S_IRR, 300, o);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n              = 1'b0;
    bus.tick             = 1'b0;
    bus.low_water_level  = 1'b1;
    bus.mid_water_level  = 1'b0;
    bus.high_water_level = 1'b0;
    bus.earth_humidity   = 1'b1;
    bus.air_humidity     = 1'b0;
    bus.low_temperature  = 1'b0;
    bus.start_request    = 1'b0;
    bus.abort            = 1'b0;

    clk1();
    ex("reset_hold", S_IDLE, 0, O_NONE);
    bus.mid_water_level = 1'b1;
    reset_n = 1'b1;
    clk1();
    ex("reset_release", S_IDLE, 0, O_NONE);

    // Sprinkler run, mode held despite air turning humid mid-run
    bus.earth_humidity = 1'b0;
    clk1();
    ex("a_settle3", S_SETTLE, 3, O_BUSY);
    clk1();
    ex("a_no_tick_hold", S_SETTLE, 3, O_BUSY);
    tk();
    ex("a_settle2", S_SETTLE, 2, O_BUSY);
    tk();
    ex("a_settle1", S_SETTLE, 1, O_BUSY);
    tk();
    ex("a_irr_spr", S_IRR, 300, O_SPR);
    run_ticks(100);
    ex("a_irr_200", S_IRR, 200, O_SPR);
    bus.air_humidity = 1'b1;
    run_ticks(199);
    ex("a_irr_1", S_IRR, 1, O_SPR);
    bus.air_humidity = 1'b0;
    tk();
    ex("a_holdoff", S_HOLD, 10, O_NONE);
    bus.earth_humidity = 1'b1;
    bus.start_request  = 1'b1;
    clk1();
    bus.start_request  = 1'b0;
    ex("a_hold_start_ign", S_HOLD, 10, O_NONE);
    run_ticks(9);
    ex("a_hold_1", S_HOLD, 1, O_NONE);
    tk();
    ex("a_idle", S_IDLE, 0, O_NONE);

    // Dripper run; soil-wet exit coinciding with a tick loads the hold-off time
    bus.air_humidity = 1'b1;
    start_irrigation("b", O_DRIP);
    bus.air_humidity = 1'b0;
    run_ticks(50);
    ex("b_irr_drip_250", S_IRR, 250, O_DRIP);
    bus.earth_humidity = 1'b1;
    tk();
    ex("b_wet_exit_tick", S_HOLD, 10, O_NONE);
    run_ticks(10);
    ex("b_idle", S_IDLE, 0, O_NONE);

    // Water loss during irrigation, then tank full ends refill
    bus.air_humidity = 1'b1;
    start_irrigation("c", O_DRIP);
    bus.low_water_level = 1'b0;
    bus.mid_water_level = 1'b0;
    clk1();
    ex("c_water_loss", S_REFILL, 120, O_REF_LO);
    bus.low_water_level  = 1'b1;
    bus.mid_water_level  = 1'b1;
    bus.high_water_level = 1'b1;
    bus.earth_humidity   = 1'b1;
    clk1();
    ex("c_full_idle", S_IDLE, 0, O_NONE);
    bus.high_water_level = 1'b0;
    bus.air_humidity     = 1'b0;

    // Refill timeout, fault acknowledge blocked by conflict
    bus.low_water_level = 1'b0;
    bus.mid_water_level = 1'b0;
    clk1();
    ex("d_refill", S_REFILL, 120, O_REF_LO);
    run_ticks(119);
    ex("d_refill_1", S_REFILL, 1, O_REF_LO);
    tk();
    ex("d_timeout_fault", S_FAULT, 0, O_FAULT);
    bus.high_water_level = 1'b1;
    pulse_abort();
    ex("d_abort_conflict", S_FAULT, 0, O_FAULT);
    bus.low_water_level = 1'b1;
    bus.mid_water_level = 1'b1;
    pulse_abort();
    ex("d_abort_clear", S_IDLE, 0, O_NONE);
    bus.high_water_level = 1'b0;

    // Abort during settling
    bus.earth_humidity = 1'b0;
    clk1();
    tk();
    ex("s_settle2", S_SETTLE, 2, O_BUSY);
    bus.earth_humidity = 1'b1;
    pulse_abort();
    ex("s_abort_idle", S_IDLE, 0, O_NONE);

    // Conflict beats timer expiry in the same cycle
    start_irrigation("e", O_SPR);
    run_ticks(299);
    ex("e_irr_1", S_IRR, 1, O_SPR);
    bus.high_water_level = 1'b1;
    bus.mid_water_level  = 1'b0;
    tk();
    ex("e_conflict_fault", S_FAULT, 0, O_FAULT);
    bus.high_water_level = 1'b0;
    bus.mid_water_level  = 1'b1;
    bus.earth_humidity   = 1'b1;
    pulse_abort();
    ex("e_ack_idle", S_IDLE, 0, O_NONE);

    // Asynchronous reset mid-irrigation
    start_irrigation("f", O_SPR);
    clk1();
    bus.earth_humidity  = 1'b1;
    bus.mid_water_level = 1'b0;
    reset_n = 1'b0;
    #1;
    ex("f_async_reset", S_IDLE, 0, O_NONE);
    clk1();
    ex("f_reset_alarm0", S_IDLE, 0, O_NONE);
    reset_n = 1'b1;
    clk1();
    ex("f_release_alarm", S_IDLE, 0, 5'b00010);
    bus.mid_water_level = 1'b1;

    repeat (3) clk1();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): SETTLE_TIME, 3, ticks of sensor settling before irrigation.
REQ-002 IRRIGATION_TIME, 300, ticks of one irrigation run.
REQ-003 HOLDOFF_TIME, 10, minimum ticks off after a run.
REQ-004 REFILL_TIMEOUT, 120, maximum ticks of refill before fault; all parameters SHALL be 1..1023.
REQ-005 Ports SHALL be (name direction width meaning): clock in 1 system clock, rising edge.
REQ-006 reset_n in 1 reset; one clock; reset is asynchronous and active-low.
REQ-007 tick in 1 one-cycle pulse per second, synchronous to clock.
REQ-008 low_water_level, mid_water_level, high_water_level in 1 each; 1 = water at or above that level.
REQ-009 earth_humidity in 1 (1 = soil wet); air_humidity in 1 (1 = air humid); low_temperature in 1 (1 = cold).
REQ-010 start_request in 1 one-cycle manual start; abort in 1 one-cycle abort, also fault acknowledge.
REQ-011 splinker_bomb out 1; dripper_valvule out 1; water_supply_valvule out 1; alarm out 1; busy out 1.
REQ-012 state out 3 current state code; remaining out 10 ticks left in the current timed state.

Function
REQ-013 conflict SHALL be (high & !mid) | (mid & !low) | (high & !low), evaluated combinationally every cycle.
REQ-014 States and codes SHALL be IDLE=0, SETTLE=1, IRRIGATE=2, REFILL=3, HOLDOFF=4, FAULT=5; codes 6-7 SHALL go to FAULT next edge.
REQ-015 All outputs SHALL be registered, decoded from next state, so outputs and state change on the same edge.
REQ-016 Exit priority in every non-FAULT state SHALL be: conflict > abort > water loss > timer/humidity.
REQ-017 IDLE: conflict -> FAULT; else !low -> REFILL; else (!earth_humidity | start_request) -> SETTLE, remaining = SETTLE_TIME.
REQ-018 SETTLE: tick decrements remaining; abort -> IDLE; tick with remaining==1 -> REFILL if !low, else IRRIGATE with remaining = IRRIGATION_TIME.
REQ-019 On IRRIGATE entry, mode SHALL be latched: sprinkler if mid & !air_humidity & !low_temperature, else dripper; mode is held for the whole run.
REQ-020 IRRIGATE: splinker_bomb = sprinkler mode, dripper_valvule = !sprinkler mode; exactly one is 1.
REQ-021 IRRIGATE exits: abort, earth_humidity==1, or tick with remaining==1 -> HOLDOFF, remaining = HOLDOFF_TIME; !low -> REFILL.
REQ-022 REFILL: water_supply_valvule=1, remaining loads REFILL_TIMEOUT on entry; high -> IDLE; abort -> IDLE; tick with remaining==1 -> FAULT.
REQ-023 HOLDOFF: all valves 0; start_request ignored; tick with remaining==1 -> IDLE.
REQ-024 FAULT: all valves 0, alarm=1; exit to IDLE only on abort while conflict==0.
REQ-025 alarm SHALL be 1 in FAULT, or when mid_water_level==0 in any state.
REQ-026 busy SHALL be 1 in SETTLE, IRRIGATE, REFILL.
REQ-027 remaining SHALL be 0 in IDLE and FAULT; it SHALL decrement only on tick and never wrap below 0.
REQ-028 A state exit and a tick on the same edge SHALL apply the exit; the new state's load value wins.
REQ-029 start_request outside IDLE SHALL be dropped, not queued.

Reset
REQ-030 reset_n low SHALL immediately force state=IDLE, remaining=0, mode=dripper, all valve outputs 0, busy=0.
REQ-031 alarm during reset SHALL be 0; after release it follows REQ-025 from the first edge.
REQ-032 Reset asserted mid-IRRIGATE or mid-REFILL SHALL close all valves without waiting for a clock edge.

Verification
REQ-033 low=mid=1, high=0, air=0, temp=0, earth=0 -> SETTLE 3 ticks -> IRRIGATE, splinker_bomb=1, remaining=300, after 300 ticks HOLDOFF, 10 ticks -> IDLE.
REQ-034 Same with air_humidity=1, toggled to 0 mid-run -> dripper_valvule=1 for the whole run; splinker_bomb stays 0.
REQ-035 In IRRIGATE, drive low=0, mid=0 -> next edge REFILL, valves 0, water_supply_valvule=1, alarm=1; raise low, mid, high -> IDLE.
REQ-036 REFILL with high held 0 for 120 ticks -> FAULT, alarm=1; abort while conflict=1 -> stays FAULT; clear conflict, abort -> IDLE.
REQ-037 Drive high=1, mid=0 in IRRIGATE together with a tick at remaining==1 -> FAULT, not HOLDOFF.
REQ-038 Assert reset_n=0 between clock edges in IRRIGATE -> valves 0 and state=0 before the next edge.
